// File: rtl/fe_inst_queue_if.sv
// Handshake bundle between FE_STAGE, the instruction queue and DE_STAGE.
// master = pipeline side (FE producer / DE consumer), slave = fe_inst_queue.
interface fe_inst_queue_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              fe_valid;
  logic [DATA_W-1:0] fe_pc;
  logic [DATA_W-1:0] fe_inst;
  logic              fe_ready;

  logic              de_valid;
  logic [DATA_W-1:0] de_pc;
  logic [DATA_W-1:0] de_inst;
  logic              de_ready;

  modport master (
    output fe_valid, fe_pc, fe_inst, de_ready,
    input  fe_ready, de_valid, de_pc, de_inst
  );

  modport slave (
    input  fe_valid, fe_pc, fe_inst, de_ready,
    output fe_ready, de_valid, de_pc, de_inst
  );

endinterface

// File: rtl/fe_inst_queue.sv
// FE->DE instruction queue: circular buffer of {pc, inst}, flushable, with FE stall counter.
// Optional same-cycle empty-queue bypass when FE_INST_QUEUE_BYPASS_EN is defined.
module fe_inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  fe_inst_queue_if.slave           q,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cycles
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fe_inst_queue: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     stall_q, stall_d;

  logic empty;
  logic full;
  logic byp_active;
  logic byp_take;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

`ifdef FE_INST_QUEUE_BYPASS_EN
  assign byp_active = empty && q.fe_valid && !flush;
`else
  assign byp_active = 1'b0;
`endif

  // A bypassed entry accepted by DE in the same cycle never touches storage.
  assign byp_take = byp_active && q.de_ready;
  assign push     = q.fe_valid && !full && !flush && !byp_take;
  assign pop      = !empty && q.de_ready && !flush;

  always_comb begin
    q.fe_ready = !full;
    q.de_valid = (!empty || byp_active) && !flush;
    q.de_pc    = '0;
    q.de_inst  = '0;
    if (byp_active) begin
      q.de_pc   = q.fe_pc;
      q.de_inst = q.fe_inst;
    end else if (q.de_valid) begin
      q.de_pc   = pc_mem[head_q];
      q.de_inst = inst_mem[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    // Counted regardless of flush; saturates rather than wrapping.
    if (q.fe_valid && full && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= q.fe_pc;
      inst_mem[tail_q] <= q.fe_inst;
    end
  end

  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fe_inst_queue.sv
// Directed self-checking bench for fe_inst_queue (DEPTH=4, DATA_W=32).
// Follows FE_INST_QUEUE_BYPASS_EN to select the expected bypass behaviour.
module tb_fe_inst_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [2:0]  count;
  logic [31:0] stall_cycles;

  int n_cmp;
  int n_err;

  fe_inst_queue_if #(.DATA_W(32)) q_if ();

  fe_inst_queue #(
    .DEPTH  (4),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .q            (q_if.slave),
    .flush        (flush),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fe(input logic v, input logic [31:0] pc);
    q_if.fe_valid = v;
    q_if.fe_pc    = pc;
    q_if.fe_inst  = inst_of(pc);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    q_if.de_ready = 1'b0;
    drive_fe(1'b0, 32'h0);
    tick();
    tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_fe_ready", q_if.fe_ready, 1);
    check_eq("rst_de_valid", q_if.de_valid, 0);
    check_eq("rst_de_pc", q_if.de_pc, 0);
    check_eq("rst_de_inst", q_if.de_inst, 0);
    check_eq("rst_stall", stall_cycles, 0);
    reset = 1'b0;

    // Three pushes with DE stalled, then three pops in order.
    drive_fe(1'b1, 32'h100); tick();
    drive_fe(1'b1, 32'h104); tick();
    drive_fe(1'b1, 32'h108); tick();
    drive_fe(1'b0, 32'h0);
    #1;
    check_eq("fill3_count", count, 3);
    check_eq("fill3_head", q_if.de_pc, 32'h100);
    q_if.de_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("pop_valid", q_if.de_valid, 1);
      check_eq("pop_pc", q_if.de_pc, 32'h100 + 32'(4 * i));
      check_eq("pop_inst", q_if.de_inst, inst_of(32'h100 + 32'(4 * i)));
      tick();
    end
    q_if.de_ready = 1'b0;
    #1;
    check_eq("drain_count", count, 0);
    check_eq("drain_valid", q_if.de_valid, 0);

    // Fill to full with DE stalled for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      drive_fe(1'b1, 32'h400 + 32'(4 * i));
      #1;
      check_eq("full_fe_ready", q_if.fe_ready, (i < 4) ? 1 : 0);
      tick();
    end
    #1;
    check_eq("full_count", count, 4);
    check_eq("full_stall", stall_cycles, 2);

    // Full with pop: only the pop happens.
    drive_fe(1'b1, 32'h4F0);
    q_if.de_ready = 1'b1;
    #1;
    check_eq("fullpop_head", q_if.de_pc, 32'h400);
    tick();
    drive_fe(1'b0, 32'h0);
    q_if.de_ready = 1'b0;
    #1;
    check_eq("fullpop_count", count, 3);
    check_eq("fullpop_fe_ready", q_if.fe_ready, 1);
    check_eq("fullpop_head2", q_if.de_pc, 32'h404);
    check_eq("fullpop_stall", stall_cycles, 3);

    // Flush with three queued and an FE entry presented.
    flush = 1'b1;
    drive_fe(1'b1, 32'h500);
    #1;
    check_eq("flush_de_valid", q_if.de_valid, 0);
    tick();
    flush = 1'b0;
    drive_fe(1'b0, 32'h0);
    #1;
    check_eq("flush_count", count, 0);
    check_eq("flush_valid", q_if.de_valid, 0);
    check_eq("flush_fe_ready", q_if.fe_ready, 1);
    check_eq("flush_stall", stall_cycles, 3);
    drive_fe(1'b1, 32'h504); tick();
    drive_fe(1'b0, 32'h0);
    #1;
    check_eq("postflush_count", count, 1);
    check_eq("postflush_head", q_if.de_pc, 32'h504);
    q_if.de_ready = 1'b1;
    tick();
    q_if.de_ready = 1'b0;

    // Streaming push/pop pairs across pointer wrap.
    drive_fe(1'b1, 32'h200);
    tick();
    q_if.de_ready = 1'b1;
    for (int k = 1; k < 10; k++) begin
      drive_fe(1'b1, 32'h200 + 32'(4 * k));
      #1;
      check_eq("stream_pc", q_if.de_pc, 32'h200 + 32'(4 * (k - 1)));
      tick();
      check_eq("stream_count", count, 1);
    end
    q_if.de_ready = 1'b0;
    drive_fe(1'b1, 32'h228); tick();
    drive_fe(1'b1, 32'h22C); tick();
    drive_fe(1'b0, 32'h0);
    #1;
    check_eq("stream_tail_head", q_if.de_pc, 32'h224);
    check_eq("stream_tail_count", count, 3);

    // Asynchronous reset mid-cycle.
    #1;
    reset = 1'b1;
    #1;
    check_eq("async_rst_count", count, 0);
    check_eq("async_rst_valid", q_if.de_valid, 0);
    check_eq("async_rst_stall", stall_cycles, 0);
    tick();
    reset = 1'b0;

    // Empty-queue presentation: bypass or one-cycle latency.
    drive_fe(1'b1, 32'h300);
    q_if.de_ready = 1'b1;
    #1;
`ifdef FE_INST_QUEUE_BYPASS_EN
    check_eq("byp_valid", q_if.de_valid, 1);
    check_eq("byp_pc", q_if.de_pc, 32'h300);
    tick();
    drive_fe(1'b0, 32'h0);
    #1;
    check_eq("byp_count", count, 0);
    check_eq("byp_valid_after", q_if.de_valid, 0);
`else
    check_eq("nobyp_valid0", q_if.de_valid, 0);
    tick();
    drive_fe(1'b0, 32'h0);
    #1;
    check_eq("nobyp_valid1", q_if.de_valid, 1);
    check_eq("nobyp_pc", q_if.de_pc, 32'h300);
    tick();
    check_eq("nobyp_count", count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fe_inst_queue.md
# fe_inst_queue

Instruction fetch queue placed between FE_STAGE and DE_STAGE inside the pipeline frame. It buffers up to DEPTH fetched {PC, instruction} pairs so that FE keeps fetching while DE stalls. It drops all buffered entries on a redirect flush from AGEX. It also counts FE back-pressure cycles for performance debugging.

## Interface
- DEPTH, 4, number of entries; a power of two, at least 2
- DATA_W, 32, PC and instruction width (matches `DBITS)
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- fe_valid  input  1  FE presents a fetched entry
- fe_pc  input  DATA_W  PC of the fetched entry
- fe_inst  input  DATA_W  instruction word
- fe_ready  output  1  queue accepts an entry this cycle
- de_valid  output  1  head entry is valid for DE
- de_pc  output  DATA_W  head PC
- de_inst  output  DATA_W  head instruction
- de_ready  input  1  DE consumes the head this cycle
- flush  input  1  branch/jump redirect from AGEX; discards all entries
- count  output  $clog2(DEPTH)+1  current occupancy
- stall_cycles  output  32  number of cycles with fe_valid=1 and fe_ready=0; saturates

## Operation
- Storage is a circular buffer with head and tail pointers of $clog2(DEPTH) bits each. The pointers wrap naturally.
- Push: fe_valid && fe_ready && !flush. The entry is written at tail, tail increments, count increments.
- Pop: de_valid && de_ready && !flush. Head increments, count decrements.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- fe_ready = (count != DEPTH). It does not depend on de_ready, so there is no combinational ready path.
  - When the queue is full, a same-cycle pop does not enable a push.
- de_valid = (count != 0) && !flush.
  - de_pc and de_inst are driven from the head entry.
  - When de_valid=0, de_pc and de_inst are don't-care.
- flush has priority over push and pop. On the next edge, head = tail = 0 and count = 0.
  - The FE entry presented during the flush cycle is discarded.
- stall_cycles increments each cycle in which fe_valid && !fe_ready, including flush cycles. It holds at 0xFFFFFFFF once it reaches that value. It is not cleared by flush.
- An illegal DEPTH must be rejected at elaboration.

## Timing
- Reset values (asynchronous): head=0, tail=0, count=0, stall_cycles=0. Consequently fe_ready=1, de_valid=0, de_pc=0, de_inst=0.
  - Storage contents are not reset.
- Latency without bypass: an entry pushed at edge N is visible on de_valid in cycle N+1.
- Throughput is one push and one pop per cycle in steady state.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Wrap-around: after DEPTH pushes and DEPTH pops, the pointers return to 0 and ordering stays FIFO.

## Configuration
- FE_INST_QUEUE_BYPASS_EN defined:
  - When count==0 and fe_valid && !flush, de_valid=1 and de_pc/de_inst are driven directly from fe_pc/fe_inst in the same cycle.
  - If de_ready is also 1, the entry is consumed without being written, and count stays 0.
  - If de_ready is 0, the entry is written as a normal push.
- FE_INST_QUEUE_BYPASS_EN undefined:
  - No combinational path exists from fe_* to de_*.
  - Minimum latency is 1 cycle.

## Test plan
- Reset, then push PCs 0x100, 0x104, 0x108 with de_ready=0. Required: count=3, de_pc=0x100. Then pop three times. Required: de_pc shows 0x100, 0x104, 0x108 in that order, and count returns to 0.
- DEPTH=4, fe_valid held at 1, de_ready=0 for 6 cycles. Required: fe_ready=0 from cycle 4, count=4, and stall_cycles=2.
- Full queue with fe_valid=1 and de_ready=1 for one cycle. Required: one pop only, count=3, fe_ready=1 in the next cycle.
- Three entries queued, then flush=1 with fe_valid=1. Required: de_valid=0 in the flush cycle; next cycle count=0, the flush-cycle entry is absent, and fe_ready=1.
- Run 10 push/pop pairs at DEPTH=4. Required: in-order output 0x200..0x224 across pointer wrap; assert reset mid-stream and check count=0 and de_valid=0 before the next edge.
- Bypass: with the macro defined, queue empty, fe_pc=0x300, de_ready=1. Required: de_valid=1 and de_pc=0x300 in the same cycle, count stays 0. With the macro undefined: de_valid=1 one cycle later.
